cs_resolver: RTL

- Converts a 32-bit carry-save pair (sum1, sum2) produced by the 4:2 compressor tree into a single binary word, modulo 2^WIDTH.
- Sits between the compressor stage and the SHA-256 round/working-variable registers.
- Uses an iterative slice-serial carry-propagate adder so the long carry chain is never built in one cycle.
- Upstream and downstream both use valid/ready handshakes.

---
 rtl/cs_resolver.sv | 101 ++++++++++
 1 files changed

// File: rtl/cs_resolver.sv
// Resolves a carry-save pair into one binary word, SLICE bits per cycle, so the
// full-width carry chain is never built in a single cycle.
module cs_resolver #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum1,
  input  logic [WIDTH-1:0] in_sum2,
  input  logic             in_ovfl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovfl
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             ovfl_lat;
  logic             accept;
  int               base;
  logic [SLICE:0]   slice_res;

  function automatic logic [SLICE:0] add_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             c);
    return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c};
  endfunction

  assign accept    = in_valid & in_ready;
  assign base      = int'(k) * SLICE;
  assign slice_res = add_slice(a_lat[base +: SLICE], b_lat[base +: SLICE], carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // DONE forwards out_ready to in_ready so a handshake edge can also accept.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (k == K_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = in_valid ? BUSY : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture: only the accept edge samples the inputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_lat    <= in_sum1;
      b_lat    <= in_sum2;
      ovfl_lat <= in_ovfl;
    end
  end

  // Slice-serial carry propagation, LSB slice first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_ovfl <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      carry <= 1'b0;
    end else if (state == BUSY) begin
      out_sum[base +: SLICE] <= slice_res[SLICE-1:0];
      carry                  <= slice_res[SLICE];
      k                      <= k + CW'(1);
      if (k == K_LAST) out_ovfl <= ovfl_lat | slice_res[SLICE];
    end
  end

endmodule
